// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Arbiter states, owner encoding and the bus-error fetch filler instruction.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_I = 2'd1,
        ACC_D = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // ADDI x0,x0,0 handed to fetch when its access times out
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int BE_W = 4;

endpackage

// File: rtl/imem_dmem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM stage.
// One access in flight at a time; data wins ties unless fetch has been starved.
module imem_dmem_port_arbiter #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                MAX_STARVE = 3,
    parameter int                TIMEOUT    = 64,
    parameter logic [DATA_W-1:0] NOP_INSTR  = riscv_mem_pkg::NOP_INSTR
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           if_req,
    input  logic [ADDR_W-1:0]              if_addr,
    output logic [DATA_W-1:0]              if_rdata,
    output logic                           if_ack,
    output logic                           if_stall,
    input  logic                           d_req,
    input  logic                           d_we,
    input  logic [riscv_mem_pkg::BE_W-1:0] d_be,
    input  logic [ADDR_W-1:0]              d_addr,
    input  logic [DATA_W-1:0]              d_wdata,
    output logic [DATA_W-1:0]              d_rdata,
    output logic                           d_ack,
    output logic                           d_stall,
    output logic                           m_req,
    output logic                           m_we,
    output logic [riscv_mem_pkg::BE_W-1:0] m_be,
    output logic [ADDR_W-1:0]              m_addr,
    output logic [DATA_W-1:0]              m_wdata,
    input  logic [DATA_W-1:0]              m_rdata,
    input  logic                           m_ack,
    output logic                           owner,
    output logic                           busy,
    output logic                           bus_err
);
    import riscv_mem_pkg::*;

    localparam int SW = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    arb_state_t          state_q;
    logic [SW-1:0]       starve_q;
    logic [TW-1:0]       tmo_q;
    logic                owner_q;
    logic                m_req_q, m_we_q;
    logic [BE_W-1:0]     m_be_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_wdata_q;
    logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;
    logic                if_ack_q, d_ack_q, bus_err_q;

    logic starved, grant_i, grant_d;

    assign starved = (starve_q == SW'(MAX_STARVE));
    assign grant_i = if_req & (~d_req | starved);
    assign grant_d = d_req & ~grant_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            tmo_q      <= '0;
            owner_q    <= 1'b0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_be_q     <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    tmo_q <= '0;
                    if (grant_i) begin
                        state_q   <= ACC_I;
                        owner_q   <= OWNER_I;
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_be_q    <= '1;
                        m_addr_q  <= if_addr & ~ADDR_W'(3);
                        m_wdata_q <= '0;
                        starve_q  <= '0;
                    end else if (grant_d) begin
                        state_q   <= ACC_D;
                        owner_q   <= OWNER_D;
                        m_req_q   <= 1'b1;
                        m_we_q    <= d_we;
                        m_be_q    <= d_be;
                        m_addr_q  <= d_addr;
                        m_wdata_q <= d_wdata;
                        // only grants that make fetch wait count toward starvation
                        starve_q  <= !if_req ? '0 : (starved ? starve_q : starve_q + 1'b1);
                    end
                end
                ACC_I, ACC_D: begin
                    if (m_ack) begin
                        m_req_q <= 1'b0;
                        state_q <= RESP;
                        if (owner_q == OWNER_I) begin
                            if_rdata_q <= m_rdata;
                            if_ack_q   <= 1'b1;
                        end else begin
                            d_rdata_q <= m_rdata;
                            d_ack_q   <= 1'b1;
                        end
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        m_req_q   <= 1'b0;
                        bus_err_q <= 1'b1;
                        state_q   <= RESP;
                        if (owner_q == OWNER_I) begin
                            if_rdata_q <= NOP_INSTR;
                            if_ack_q   <= 1'b1;
                        end else begin
                            d_rdata_q <= '0;
                            d_ack_q   <= 1'b1;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_be     = m_be_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_ack   = if_ack_q;
    assign d_ack    = d_ack_q;
    assign owner    = owner_q;
    assign busy     = (state_q != IDLE);
    assign bus_err  = bus_err_q;
    assign if_stall = if_req & ~if_ack_q;
    assign d_stall  = d_req & ~d_ack_q;

endmodule
